commit_trace_buffer: RTL

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: FIFO trace of retired register-file writes (rd!=0), DEPTH entries; TRACE_DROP_CNT_EN adds drop_count.
// Latency: push edge to trace_valid is one cycle (no fall-through); head fields are registered and hold when empty.
// Backpressure: valid/ready pop; a push into a full buffer without a same-edge pop is dropped and sets sticky overflow.
module commit_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       regwrite,
    input  logic [4:0]                 rd,
    input  logic [63:0]                writeData,
    input  logic [63:0]                pc_out,
    input  logic                       clear,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [63:0]                trace_pc,
    output logic [4:0]                 trace_rd,
    output logic [63:0]                trace_data,
    output logic [$clog2(DEPTH):0]     count,
`ifdef TRACE_DROP_CNT_EN
    output logic [15:0]                drop_count,
`endif
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_q;
    entry_t          head_d;
    entry_t          new_ent;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt_q;
    logic            push_req;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    always_comb begin
        new_ent  = '{pc: pc_out, rd: rd, data: writeData};
        push_req = regwrite && (rd != 5'd0);
        full     = (cnt_q == CW'(DEPTH));
        pop      = (cnt_q != '0) && trace_ready;
        // A pop frees a slot on the same edge, so a full buffer still accepts.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        // Head register tracks the entry that will be at rd_ptr after this edge.
        head_d = head_q;
        if (pop) begin
            if (cnt_q == CW'(1)) begin
                if (push) begin
                    head_d = new_ent;
                end
            end else begin
                head_d = mem[rd_ptr + AW'(1)];
            end
        end else if ((cnt_q == '0) && push) begin
            head_d = new_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= new_ent;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            head_q   <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            head_q <= head_d;
        end
    end

`ifdef TRACE_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (clear) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

    assign trace_valid = (cnt_q != '0);
    assign trace_pc    = head_q.pc;
    assign trace_rd    = head_q.rd;
    assign trace_data  = head_q.data;
    assign count       = cnt_q;

endmodule
